// File: rtl/tdm_pkg.sv
// Shared types and sizing constants for the TDM receive path.
// The transmit-side serializer is expected to reuse these.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    localparam int TDM_DATA_WIDTH = 4;
    localparam int TDM_SEL_WIDTH  = 2;
    localparam int TDM_MISS_WIDTH = 3;

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot index counter with increment, load-to-one and clear.
// Clear wins over load, load wins over increment.
module tdm_slot_counter #(
    parameter int SEL_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 load_one,
    input  logic                 clear,
    output logic [SEL_WIDTH-1:0] count
);

    logic [SEL_WIDTH-1:0] count_q;
    logic [SEL_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load_one) begin
            count_d = SEL_WIDTH'(1);
        end else if (en) begin
            count_d = count_q + SEL_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tdm_demux_1to4.sv
// TDM serial-to-parallel receiver: frame-sync alignment, lock tracking
// with a missing-marker tolerance, and one-cycle word/sync-error strobes.
module tdm_demux_1to4
    import tdm_pkg::*;
#(
    parameter int DATA_WIDTH = TDM_DATA_WIDTH,
    parameter int SEL_WIDTH  = TDM_SEL_WIDTH,
    parameter int MISS_LIMIT = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    input  logic                  din_valid,
    input  logic                  frame_sync,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  out_valid,
    output logic [SEL_WIDTH-1:0]  slot,
    output logic                  locked,
    output logic                  sync_err
);

    localparam logic [SEL_WIDTH-1:0]      LAST_SLOT = SEL_WIDTH'(DATA_WIDTH - 1);
    localparam logic [TDM_MISS_WIDTH-1:0] MISS_MAX  = TDM_MISS_WIDTH'(MISS_LIMIT);

    tdm_state_e                state_q, state_d;
    logic [TDM_MISS_WIDTH-1:0] miss_q, miss_d, miss_inc;
    logic [DATA_WIDTH-2:0]     shadow_q, shadow_d;
    logic [DATA_WIDTH-1:0]     out_q, out_d;
    logic                      out_valid_q, out_valid_d;
    logic                      sync_err_q, sync_err_d;
    logic                      locked_q, locked_d;
    logic                      slot_en, slot_load_one, slot_clear;
    logic [SEL_WIDTH-1:0]      slot_cnt;

    tdm_slot_counter #(
        .SEL_WIDTH (SEL_WIDTH)
    ) u_slot_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (slot_en),
        .load_one (slot_load_one),
        .clear    (slot_clear),
        .count    (slot_cnt)
    );

    // A frame_sync beat always realigns to slot 0, so it is never a miss.
    always_comb begin
        state_d       = state_q;
        miss_d        = miss_q;
        miss_inc      = miss_q + TDM_MISS_WIDTH'(1);
        shadow_d      = shadow_q;
        out_d         = out_q;
        out_valid_d   = 1'b0;
        sync_err_d    = 1'b0;
        slot_en       = 1'b0;
        slot_load_one = 1'b0;
        slot_clear    = 1'b0;

        if (din_valid) begin
            case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_d[0]   = din;
                        slot_load_one = 1'b1;
                        miss_d        = '0;
                        state_d       = LOCKED;
                    end
                end
                LOCKED: begin
                    if (frame_sync) begin
                        sync_err_d    = (slot_cnt != '0);
                        shadow_d[0]   = din;
                        slot_load_one = 1'b1;
                        miss_d        = '0;
                    end else if (slot_cnt == '0) begin
                        if (miss_inc == MISS_MAX) begin
                            state_d    = HUNT;
                            slot_clear = 1'b1;
                            miss_d     = '0;
                        end else begin
                            miss_d      = miss_inc;
                            shadow_d[0] = din;
                            slot_en     = 1'b1;
                        end
                    end else begin
                        for (int i = 1; i < DATA_WIDTH - 1; i++) begin
                            if (slot_cnt == SEL_WIDTH'(i)) begin
                                shadow_d[i] = din;
                            end
                        end
                        if (slot_cnt == LAST_SLOT) begin
                            out_d       = {din, shadow_q};
                            out_valid_d = 1'b1;
                        end
                        slot_en = 1'b1;
                    end
                end
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            miss_q      <= '0;
            shadow_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_q      <= miss_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            locked_q    <= locked_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign slot      = slot_cnt;
    assign locked    = locked_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Self-checking bench for tdm_demux_1to4: directed frame scenarios plus
// randomized traffic checked every cycle against a frame-level reference model.
module tb_tdm_demux_1to4;

    localparam int DW = 4;
    localparam int SW = 2;
    localparam int ML = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din = 1'b0;
    logic          din_valid = 1'b0;
    logic          frame_sync = 1'b0;
    logic [DW-1:0] out;
    logic          out_valid;
    logic [SW-1:0] slot;
    logic          locked;
    logic          sync_err;

    int numAsserts = 0;
    int numFails   = 0;
    int pulseCount = 0;
    int errCount   = 0;

    // Reference model: collected bits of the frame in progress and the
    // position of the next bit within it.
    bit       mLocked = 0;
    int       mPos    = 0;
    int       mMiss   = 0;
    bit [3:0] mBits   = '0;
    bit [3:0] mOut    = '0;
    bit       mValid  = 0;
    bit       mErr    = 0;

    bit       trackWords = 0;
    bit [3:0] expWords[$];

    tdm_demux_1to4 #(
        .DATA_WIDTH (DW),
        .SEL_WIDTH  (SW),
        .MISS_LIMIT (ML)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .out        (out),
        .out_valid  (out_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numAsserts++;
        assert (obs === exp) else begin
            numFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input bit r, input bit d, input bit v, input bit s);
        mValid = 0;
        mErr   = 0;
        if (!r) begin
            mLocked = 0; mPos = 0; mMiss = 0; mBits = '0; mOut = '0;
        end else if (v) begin
            if (!mLocked) begin
                if (s) begin
                    mBits[0] = d; mPos = 1; mLocked = 1; mMiss = 0;
                end
            end else if (s) begin
                mErr = (mPos != 0);
                mBits[0] = d; mPos = 1; mMiss = 0;
            end else if (mPos == 0) begin
                mMiss = mMiss + 1;
                if (mMiss >= ML) begin
                    mLocked = 0; mPos = 0; mMiss = 0;
                end else begin
                    mBits[0] = d; mPos = 1;
                end
            end else begin
                mBits[mPos] = d;
                if (mPos == 3) begin
                    mOut = {d, mBits[2:0]}; mValid = 1; mPos = 0;
                end else begin
                    mPos = mPos + 1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit d, input bit v, input bit s);
        @(negedge clk);
        rst_n = r; din = d; din_valid = v; frame_sync = s;
        @(posedge clk);
        modelStep(r, d, v, s);
        #1;
        checkOutput("out",       32'(out),       32'(mOut));
        checkOutput("out_valid", 32'(out_valid), 32'(mValid));
        checkOutput("slot",      32'(slot),      32'(mPos));
        checkOutput("locked",    32'(locked),    32'(mLocked));
        checkOutput("sync_err",  32'(sync_err),  32'(mErr));
        if (out_valid === 1'b1) pulseCount++;
        if (sync_err === 1'b1) errCount++;
        if (trackWords && out_valid === 1'b1) begin
            if (expWords.size() == 0) checkOutput("extra_word", 32'(expWords.size()), 32'd1);
            else checkOutput("word", 32'(out), 32'(expWords.pop_front()));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1, 1'($urandom), 0, 1'($urandom));
    endtask

    task automatic sendFrame(input bit [3:0] w, input bit syncFirst, input int maxGap);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, w[i], 1, syncFirst && (i == 0));
            if (maxGap > 0 && i < 3) idle($urandom_range(1, maxGap));
        end
    endtask

    initial begin
        int p0;
        int e0;

        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1);
        checkOutput("rst_out",    32'(out),    32'd0);
        checkOutput("rst_locked", 32'(locked), 32'd0);
        checkOutput("rst_slot",   32'(slot),   32'd0);

        $display("[TB] basic frame");
        p0 = pulseCount;
        applyStimulus(1, 1, 1, 1);
        checkOutput("t1_locked", 32'(locked), 32'd1);
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 1, 1, 0);
        checkOutput("t1_out",   32'(out),       32'hD);
        checkOutput("t1_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_slot",  32'(slot),      32'd0);
        idle(1);
        checkOutput("t1_valid_drop", 32'(out_valid),       32'd0);
        checkOutput("t1_pulses",     32'(pulseCount - p0), 32'd1);

        $display("[TB] gapped frame");
        sendFrame(4'b0000, 1, 0);
        p0 = pulseCount;
        sendFrame(4'b1101, 1, 3);
        idle(2);
        checkOutput("t2_out",    32'(out),             32'hD);
        checkOutput("t2_pulses", 32'(pulseCount - p0), 32'd1);

        $display("[TB] misaligned sync");
        sendFrame(4'b0010, 1, 0);
        p0 = pulseCount;
        e0 = errCount;
        applyStimulus(1, 0, 1, 1);
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 1, 1, 1);
        checkOutput("t3_sync_err", 32'(sync_err),  32'd1);
        checkOutput("t3_no_valid", 32'(out_valid), 32'd0);
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 1, 1, 0);
        checkOutput("t3_out",    32'(out),             32'hD);
        checkOutput("t3_pulses", 32'(pulseCount - p0), 32'd1);
        checkOutput("t3_errs",   32'(errCount - e0),   32'd1);

        $display("[TB] missing sync");
        sendFrame(4'b0101, 1, 0);
        checkOutput("t4_out1", 32'(out), 32'h5);
        sendFrame(4'b1010, 0, 0);
        checkOutput("t4_out2",    32'(out),    32'hA);
        checkOutput("t4_locked2", 32'(locked), 32'd1);
        p0 = pulseCount;
        applyStimulus(1, 1, 1, 0);
        checkOutput("t4_unlock", 32'(locked), 32'd0);
        checkOutput("t4_slot",   32'(slot),   32'd0);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 0, 1, 0);
        applyStimulus(1, 1, 1, 0);
        checkOutput("t4_pulses", 32'(pulseCount - p0), 32'd0);
        checkOutput("t4_hold",   32'(out),             32'hA);

        $display("[TB] mid-frame reset");
        sendFrame(4'b1001, 1, 0);
        applyStimulus(1, 1, 1, 1);
        applyStimulus(1, 0, 1, 0);
        checkOutput("t5_slot2", 32'(slot), 32'd2);
        applyStimulus(0, 1, 1, 0);
        checkOutput("t5_out",    32'(out),    32'd0);
        checkOutput("t5_slot",   32'(slot),   32'd0);
        checkOutput("t5_locked", 32'(locked), 32'd0);
        sendFrame(4'b0110, 1, 0);
        checkOutput("t5_word", 32'(out), 32'h6);

        $display("[TB] random back-to-back frames");
        trackWords = 1;
        p0 = pulseCount;
        e0 = errCount;
        for (int f = 0; f < 60; f++) begin
            bit [3:0] w;
            w = 4'($urandom);
            expWords.push_back(w);
            sendFrame(w, 1, 0);
        end
        idle(1);
        trackWords = 0;
        checkOutput("t6_pulses",  32'(pulseCount - p0),  32'd60);
        checkOutput("t6_errs",    32'(errCount - e0),    32'd0);
        checkOutput("t6_pending", 32'(expWords.size()), 32'd0);

        $display("[TB] random stress");
        for (int c = 0; c < 500; c++) begin
            applyStimulus(($urandom_range(0, 99) != 0), 1'($urandom),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
        $finish;
    end

endmodule
